// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for vga_fb_arbiter: display pop side, camera write side and frame-buffer memory port.
// Stats counters exist only when FB_ARB_STATS_EN is defined.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 24
);
  logic              frame_start;
  logic              pix_pop;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underflow;
  logic              cam_valid;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic              cam_ready;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0]       underflow_cnt;
  logic [15:0]       cam_stall_cnt;
`endif

  modport slave (
    input  frame_start, pix_pop, cam_valid, cam_addr, cam_data, mem_rdata,
    output pix_data, pix_valid, underflow, cam_ready, mem_re, mem_we, mem_addr, mem_wdata
`ifdef FB_ARB_STATS_EN
    , output underflow_cnt, cam_stall_cnt
`endif
  );

  modport master (
    output frame_start, pix_pop, cam_valid, cam_addr, cam_data, mem_rdata,
    input  pix_data, pix_valid, underflow, cam_ready, mem_re, mem_we, mem_addr, mem_wdata
`ifdef FB_ARB_STATS_EN
    , input underflow_cnt, cam_stall_cnt
`endif
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display prefetch reads into an FWFT FIFO vs camera writes.
// Optional FB_ARB_STATS_EN adds saturating underflow / camera-stall counters.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned PIX_TOTAL  = 307200,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LOW_WM     = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic             clk_in,
  input logic             rst,
  vga_fb_arbiter_if.slave fb
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned CrW  = $clog2(FIFO_DEPTH + RD_LATENCY + 4) + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

  state_e                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic                  r_mem_re, r_mem_we;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic [RD_LATENCY-1:0] r_pipe_vld, r_pipe_stale;
  logic                  r_ret_vld;
  logic [DATA_W-1:0]     r_ret_data;
  logic [DATA_W-1:0]     r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wp, r_rp;
  logic [CntW-1:0]       r_cnt;
  logic                  r_underflow;

  logic [CrW-1:0]        w_credit;
  logic                  w_rd_elig, w_urgent, w_rd_gnt, w_wr_gnt;
  logic                  w_last, w_push, w_pop, w_empty;

  // Credit covers every non-stale read between grant and FIFO push, so the FIFO cannot overflow.
  always_comb begin
    w_credit = CrW'(r_cnt) + CrW'(r_mem_re) + CrW'(r_ret_vld);
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_credit = w_credit + CrW'(r_pipe_vld[i] & ~r_pipe_stale[i]);
    end
  end

  assign w_last  = (r_rd_ptr == ADDR_W'(PIX_TOTAL - 1));
  assign w_empty = (r_cnt == '0);
  assign w_push  = r_ret_vld;
  assign w_pop   = fb.pix_pop && !w_empty;

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= StDone;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (fb.frame_start)          w_state_nxt = StFetch;
    else if (w_rd_gnt && w_last) w_state_nxt = StDone;
  end

  // Grant: urgent read, else camera write, else background read.
  always_comb begin
    w_rd_elig = !rst && !fb.frame_start && (r_state == StFetch) &&
                (w_credit < CrW'(FIFO_DEPTH));
    w_urgent  = w_rd_elig && (w_credit < CrW'(LOW_WM));
    w_wr_gnt  = !rst && fb.cam_valid && !w_urgent;
    w_rd_gnt  = w_rd_elig && !w_wr_gnt;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_mem_re <= w_rd_gnt;
      r_mem_we <= w_wr_gnt;
      if (w_rd_gnt) begin
        r_mem_addr <= r_rd_ptr;
      end else if (w_wr_gnt) begin
        r_mem_addr  <= fb.cam_addr;
        r_mem_wdata <= fb.cam_data;
      end
      if (fb.frame_start) r_rd_ptr <= '0;
      else if (w_rd_gnt)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Return tracking: a read issued before frame_start is tagged stale and dropped on return.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_pipe_vld   <= '0;
      r_pipe_stale <= '0;
      r_ret_vld    <= 1'b0;
      r_ret_data   <= '0;
    end else begin
      r_pipe_vld[0]   <= r_mem_re;
      r_pipe_stale[0] <= fb.frame_start;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]   <= r_pipe_vld[i-1];
        r_pipe_stale[i] <= r_pipe_stale[i-1] | fb.frame_start;
      end
      r_ret_vld  <= r_pipe_vld[RD_LATENCY-1] & ~r_pipe_stale[RD_LATENCY-1] & ~fb.frame_start;
      r_ret_data <= fb.mem_rdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_wp] <= r_ret_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst || fb.frame_start) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
      if (fb.pix_pop && w_empty) r_underflow <= 1'b1;
    end
  end

  assign fb.pix_valid = !w_empty;
  assign fb.pix_data  = w_empty ? '0 : r_fifo[r_rp];
  assign fb.underflow = r_underflow;
  assign fb.cam_ready = w_wr_gnt;
  assign fb.mem_re    = r_mem_re;
  assign fb.mem_we    = r_mem_we;
  assign fb.mem_addr  = r_mem_addr;
  assign fb.mem_wdata = r_mem_wdata;

`ifdef FB_ARB_STATS_EN
  logic [15:0] r_uf_cnt, r_stall_cnt;

  always_ff @(posedge clk_in) begin
    if (rst || fb.frame_start) begin
      r_uf_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fb.pix_pop && w_empty && (r_uf_cnt != '1)) r_uf_cnt <= r_uf_cnt + 1'b1;
      if (fb.cam_valid && !w_wr_gnt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fb.underflow_cnt = r_uf_cnt;
  assign fb.cam_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: memory model returns {frame_salt, addr} after RD_LATENCY.
module tb_vga_fb_arbiter;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DATA_W     = 24;
  localparam int unsigned PIX_TOTAL  = 600;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned LOW_WM     = 8;
  localparam int unsigned RD_LATENCY = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fb ();

  vga_fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .PIX_TOTAL (PIX_TOTAL),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LOW_WM    (LOW_WM),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .fb    (fb)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [4:0]        salt = '0;
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_ptr = '0;
  logic              exp_uf  = 1'b0;
  logic              wr_pend = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  // Memory model: data for the read seen in cycle k is driven during cycle k+RD_LATENCY.
  initial begin
    fb.mem_rdata = '0;
    forever begin
      @(posedge clk_in);
      #1;
      hist.push_back(fb.mem_re ? {salt, fb.mem_addr} : 24'hBADBAD);
      if (hist.size() > RD_LATENCY) fb.mem_rdata = hist.pop_front();
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (rst) begin
      exp_q.delete();
      exp_ptr = '0;
      exp_uf  = 1'b0;
      wr_pend = 1'b0;
    end else begin
      check_eq("re_we_excl", 32'(fb.mem_re & fb.mem_we), 0);
      check_eq("mem_we", 32'(fb.mem_we), 32'(wr_pend));
      if (fb.mem_we && wr_pend) begin
        check_eq("wr_addr", 32'(fb.mem_addr), 32'(wr_addr));
        check_eq("wr_data", 32'(fb.mem_wdata), 32'(wr_data));
      end
      wr_pend = fb.cam_valid & fb.cam_ready;
      wr_addr = fb.cam_addr;
      wr_data = fb.cam_data;
      check_eq("underflow", 32'(fb.underflow), 32'(exp_uf));
      if (fb.mem_re) begin
        check_eq("rd_addr", 32'(fb.mem_addr), 32'(exp_ptr));
        exp_ptr = exp_ptr + 1'b1;
        if (!fb.frame_start) exp_q.push_back({salt, fb.mem_addr});
      end
      if (!fb.pix_valid) begin
        check_eq("pix_data_empty", 32'(fb.pix_data), 0);
      end else begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check_eq("pix_data", 32'(fb.pix_data), 32'(exp_q[0]));
          if (fb.pix_pop && !fb.frame_start) void'(exp_q.pop_front());
        end
      end
      if (fb.frame_start) begin
        exp_q.delete();
        exp_ptr = '0;
        exp_uf  = 1'b0;
      end else if (fb.pix_pop && !fb.pix_valid) begin
        exp_uf = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #2;
    fb.frame_start = 1'b0;
    fb.pix_pop     = 1'b0;
  endtask

  task automatic start_frame();
    step();
    fb.frame_start = 1'b1;
    salt = salt + 1'b1;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      @(negedge clk_in);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pix_valid"}, 32'(fb.pix_valid), 0);
    check_eq({tag, "_pix_data"},  32'(fb.pix_data), 0);
    check_eq({tag, "_underflow"}, 32'(fb.underflow), 0);
    check_eq({tag, "_mem_re"},    32'(fb.mem_re), 0);
    check_eq({tag, "_mem_we"},    32'(fb.mem_we), 0);
    check_eq({tag, "_mem_addr"},  32'(fb.mem_addr), 0);
    check_eq({tag, "_mem_wdata"}, 32'(fb.mem_wdata), 0);
    check_eq({tag, "_cam_ready"}, 32'(fb.cam_ready), 0);
  endtask

  initial begin
    int re_first, pv_first, nre, extra;
    logic [ADDR_W-1:0] last_addr;
    fb.frame_start = 1'b0;
    fb.pix_pop     = 1'b0;
    fb.cam_valid   = 1'b0;
    fb.cam_addr    = '0;
    fb.cam_data    = '0;

    // Reset state, nothing fetched before the first frame_start
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk_in);
    check_all_zero("reset");
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk_in);
      extra += int'(fb.mem_re);
    end
    check_eq("no_fetch_before_fs", 32'(extra), 0);

    // Initial prefetch: exactly FIFO_DEPTH reads, pix_valid 4 cycles after first mem_re
    start_frame();
    re_first = -1;
    pv_first = -1;
    nre = 0;
    last_addr = '0;
    for (int i = 1; i <= 40; i++) begin
      step();
      @(negedge clk_in);
      if (fb.mem_re) begin
        nre++;
        last_addr = fb.mem_addr;
        if (re_first < 0) re_first = i;
      end
      if (fb.pix_valid && pv_first < 0) pv_first = i;
      check_eq("cam_ready_idle", 32'(fb.cam_ready), 0);
    end
    check_eq("first_re_cycle", 32'(re_first), 2);
    check_eq("first_pv_cycle", 32'(pv_first), 6);
    check_eq("prefetch_reads", 32'(nre), FIFO_DEPTH);

    // Continuous pop over the whole frame
    for (int i = 0; i < int'(PIX_TOTAL); i++) begin
      step();
      fb.pix_pop = 1'b1;
      @(negedge clk_in);
      if (fb.mem_re) begin
        nre++;
        last_addr = fb.mem_addr;
      end
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk_in);
      extra += int'(fb.mem_re);
    end
    check_eq("frame_reads", 32'(nre), PIX_TOTAL);
    check_eq("last_rd_addr", 32'(last_addr), PIX_TOTAL - 1);
    check_eq("done_no_re", 32'(extra), 0);
    check_eq("frame_drained", 32'(fb.pix_valid), 0);
    check_eq("frame_no_uf", 32'(fb.underflow), 0);

    // Camera writes vs display reads around the low watermark
    start_frame();
    idle(25);
    for (int i = 0; i < 13; i++) begin
      step();
      fb.cam_valid = 1'b1;
      fb.cam_addr  = ADDR_W'($urandom());
      fb.cam_data  = DATA_W'($urandom());
      if (i >= 4) fb.pix_pop = 1'b1;
      @(negedge clk_in);
      check_eq("cam_ready_above_wm", 32'(fb.cam_ready), 1);
    end
    step();
    fb.cam_addr = ADDR_W'($urandom());
    fb.cam_data = DATA_W'($urandom());
    @(negedge clk_in);
    check_eq("urgent_rd_blocks_cam", 32'(fb.cam_ready), 0);
    step();
    @(negedge clk_in);
    check_eq("urgent_rd_issued", 32'(fb.mem_re), 1);
    check_eq("cam_ready_resume", 32'(fb.cam_ready), 1);
    step();
    fb.cam_valid = 1'b0;
    @(negedge clk_in);
`ifdef FB_ARB_STATS_EN
    check_eq("cam_stall_cnt", 32'(fb.cam_stall_cnt), 1);
`endif

    // frame_start with data in the FIFO and reads in flight
    start_frame();
    step();
    fb.pix_pop = 1'b1;
    @(negedge clk_in);
    check_eq("flush_pix_valid", 32'(fb.pix_valid), 0);
    idle(8);
    check_eq("uf_before_fs", 32'(fb.underflow), 1);
    check_eq("fifo_filled_pre_fs", 32'(fb.pix_valid), 1);
    start_frame();
    for (int i = 1; i <= 7; i++) begin
      step();
      @(negedge clk_in);
      check_eq("refetch_pix_valid", 32'(fb.pix_valid), 32'(i >= 6));
      if (i == 1) check_eq("uf_cleared", 32'(fb.underflow), 0);
    end

    // Pops while empty
    start_frame();
    for (int i = 0; i < 3; i++) begin
      step();
      fb.pix_pop = 1'b1;
      @(negedge clk_in);
      check_eq("empty_pop_data", 32'(fb.pix_data), 0);
    end
    step();
    @(negedge clk_in);
    check_eq("uf_sticky", 32'(fb.underflow), 1);
`ifdef FB_ARB_STATS_EN
    check_eq("underflow_cnt", 32'(fb.underflow_cnt), 3);
`endif

    // Reset mid-fetch with reads in flight
    step();
    rst = 1'b1;
    @(negedge clk_in);
    step();
    rst = 1'b0;
    @(negedge clk_in);
    check_all_zero("mid_rst");
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk_in);
      extra += int'(fb.mem_re) + int'(fb.pix_valid);
    end
    check_eq("post_rst_quiet", 32'(extra), 0);
    start_frame();
    idle(12);
    check_eq("post_rst_refetch", 32'(fb.pix_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
